// File: rtl/pyramid_gradient.sv
// ----------------------------------------------------------------------------
// pyramid_gradient
// Computes spatial (ix, iy) and temporal (it) gradients for one pyramid level.
// For each pixel, five reads are issued to the previous-frame and
// current-frame level BRAMs (center, left, right, up, down; edges replicated).
// Then the central differences are formed and presented on a valid/ready port.
//
// Ports
//   clk, rst                    single clock, synchronous active-high reset
//   start                       request to process one level (IDLE only)
//   level_width, level_height   level dimensions, sampled on accepted start
//   rd_addr, rd_en              shared BRAM read port (1-cycle read latency)
//   prev_rd_data, curr_rd_data  previous-frame (A) / current-frame (B) pixel
//   ix, iy, it                  signed gradients
//   grad_addr                   raster index y*W+x of the gradient
//   grad_valid, grad_ready      output handshake
//   grad_last                   marks pixel (W-1, H-1)
//   busy, done, err_dims        status; done / err_dims are 1-cycle pulses
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; bad dimensions pulse err_dims + done
// READ    | issuing the five tap reads, capturing the previous tap's data
// CALC    | down tap arrives; gradients registered
// OUT     | grad_valid held until grad_ready
// DONE_ST | level complete; done pulse visible
// ----------------------------------------------------------------------------
module pyramid_gradient #(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_WIDTH   = 320,
    parameter int MAX_HEIGHT  = 240,
    parameter int ADDR_WIDTH  = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [8:0]                    level_width,
    input  logic [7:0]                    level_height,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_en,
    input  logic [PIXEL_WIDTH-1:0]        prev_rd_data,
    input  logic [PIXEL_WIDTH-1:0]        curr_rd_data,
    output logic signed [PIXEL_WIDTH:0]   ix,
    output logic signed [PIXEL_WIDTH:0]   iy,
    output logic signed [PIXEL_WIDTH:0]   it,
    output logic [ADDR_WIDTH-1:0]         grad_addr,
    output logic                          grad_valid,
    input  logic                          grad_ready,
    output logic                          grad_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err_dims
);

    typedef enum logic [2:0] {IDLE, READ, CALC, OUT, DONE_ST} state_t;

    localparam logic [2:0] TAP_CENTER = 3'd0;
    localparam logic [2:0] TAP_LEFT   = 3'd1;
    localparam logic [2:0] TAP_RIGHT  = 3'd2;
    localparam logic [2:0] TAP_UP     = 3'd3;
    localparam logic [2:0] TAP_DOWN   = 3'd4;

    state_t                 state;
    logic [8:0]             x, w;
    logic [7:0]             y, h;
    logic [2:0]             tap;
    logic [PIXEL_WIDTH-1:0] a_center, a_left, a_right, a_up, b_center;

    logic       dims_bad;
    logic       pixel_last;
    logic [8:0] x_nxt;
    logic [7:0] y_nxt;

    // Address of one tap around (px, py), neighbours clamped to the level.
    function automatic logic [ADDR_WIDTH-1:0] tap_addr(
        input logic [2:0] t,
        input logic [8:0] px,
        input logic [7:0] py,
        input logic [8:0] pw,
        input logic [7:0] ph
    );
        logic [8:0] cx;
        logic [7:0] cy;
        cx = px;
        cy = py;
        case (t)
            TAP_LEFT:  cx = (px == '0)         ? px : px - 9'd1;
            TAP_RIGHT: cx = (px == pw - 9'd1)  ? px : px + 9'd1;
            TAP_UP:    cy = (py == '0)         ? py : py - 8'd1;
            TAP_DOWN:  cy = (py == ph - 8'd1)  ? py : py + 8'd1;
            default:   ;
        endcase
        return ADDR_WIDTH'(cy) * ADDR_WIDTH'(pw) + ADDR_WIDTH'(cx);
    endfunction

    // Zero-extended difference; both operands fit, so it never overflows.
    function automatic logic signed [PIXEL_WIDTH:0] diff(
        input logic [PIXEL_WIDTH-1:0] a,
        input logic [PIXEL_WIDTH-1:0] b
    );
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    assign dims_bad = (level_width < 9'd2) || (level_height < 8'd2) ||
                      ({23'd0, level_width} > MAX_WIDTH) ||
                      ({24'd0, level_height} > MAX_HEIGHT);

    assign pixel_last = (x == w - 9'd1) && (y == h - 8'd1);
    assign x_nxt      = (x == w - 9'd1) ? 9'd0 : x + 9'd1;
    assign y_nxt      = (x == w - 9'd1) ? y + 8'd1 : y;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            w          <= '0;
            h          <= '0;
            tap        <= TAP_CENTER;
            a_center   <= '0;
            a_left     <= '0;
            a_right    <= '0;
            a_up       <= '0;
            b_center   <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            ix         <= '0;
            iy         <= '0;
            it         <= '0;
            grad_addr  <= '0;
            grad_valid <= 1'b0;
            grad_last  <= 1'b0;
            done       <= 1'b0;
            err_dims   <= 1'b0;
        end else begin
            done     <= 1'b0;
            err_dims <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dims_bad) begin
                            err_dims <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            w       <= level_width;
                            h       <= level_height;
                            x       <= '0;
                            y       <= '0;
                            tap     <= TAP_CENTER;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    // Data for the tap issued last cycle is on the bus now.
                    case (tap)
                        TAP_LEFT: begin
                            a_center <= prev_rd_data;
                            b_center <= curr_rd_data;
                        end
                        TAP_RIGHT: a_left  <= prev_rd_data;
                        TAP_UP:    a_right <= prev_rd_data;
                        TAP_DOWN:  a_up    <= prev_rd_data;
                        default:   ;
                    endcase
                    if (tap == TAP_DOWN) begin
                        rd_en <= 1'b0;
                        state <= CALC;
                    end else begin
                        tap     <= tap + 3'd1;
                        rd_addr <= tap_addr(tap + 3'd1, x, y, w, h);
                    end
                end
                CALC: begin
                    // The down tap is used straight off the read bus.
                    ix         <= diff(a_right, a_left);
                    iy         <= diff(prev_rd_data, a_up);
                    it         <= diff(b_center, a_center);
                    grad_addr  <= tap_addr(TAP_CENTER, x, y, w, h);
                    grad_last  <= pixel_last;
                    grad_valid <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (grad_ready) begin
                        grad_valid <= 1'b0;
                        if (pixel_last) begin
                            done  <= 1'b1;
                            state <= DONE_ST;
                        end else begin
                            x       <= x_nxt;
                            y       <= y_nxt;
                            tap     <= TAP_CENTER;
                            rd_en   <= 1'b1;
                            rd_addr <= tap_addr(TAP_CENTER, x_nxt, y_nxt, w, h);
                            state   <= READ;
                        end
                    end
                end
                DONE_ST: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pyramid_gradient.sv
// ----------------------------------------------------------------------------
// tb_pyramid_gradient
// Drives pyramid_gradient with directed and random levels, models the two
// level BRAMs, and compares every gradient against a reference computed
// directly from the image arrays with clamped central differences.
// ----------------------------------------------------------------------------
module tb_pyramid_gradient;
    localparam int PW  = 8;
    localparam int AW  = 18;
    localparam int MEM = 4096;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [8:0]           level_width;
    logic [7:0]           level_height;
    logic [AW-1:0]        rd_addr;
    logic                 rd_en;
    logic [PW-1:0]        prev_rd_data;
    logic [PW-1:0]        curr_rd_data;
    logic signed [PW:0]   ix, iy, it;
    logic [AW-1:0]        grad_addr;
    logic                 grad_valid;
    logic                 grad_ready;
    logic                 grad_last;
    logic                 busy, done, err_dims;

    pyramid_gradient #(
        .PIXEL_WIDTH(PW), .MAX_WIDTH(320), .MAX_HEIGHT(240), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .level_width(level_width), .level_height(level_height),
        .rd_addr(rd_addr), .rd_en(rd_en),
        .prev_rd_data(prev_rd_data), .curr_rd_data(curr_rd_data),
        .ix(ix), .iy(iy), .it(it), .grad_addr(grad_addr),
        .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_last(grad_last),
        .busy(busy), .done(done), .err_dims(err_dims)
    );

    always #5 clk = ~clk;

    int prev_mem [MEM];
    int curr_mem [MEM];

    // Level BRAMs: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            prev_rd_data <= (int'(rd_addr) < MEM) ? PW'(prev_mem[int'(rd_addr)]) : '0;
            curr_rd_data <= (int'(rd_addr) < MEM) ? PW'(curr_mem[int'(rd_addr)]) : '0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int a_at(int w, int h, int px, int py);
        int cx, cy;
        cx = (px < 0) ? 0 : ((px > w - 1) ? w - 1 : px);
        cy = (py < 0) ? 0 : ((py > h - 1) ? h - 1 : py);
        return prev_mem[cy * w + cx];
    endfunction

    // mode 0: flat 100, 1: ramp 10*x with B=A+5, 2: single 255 spike at (1,1), 3: random
    task automatic fill_image(input int w, input int h, input int mode);
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                int a, b;
                case (mode)
                    0: begin a = 100; b = 100; end
                    1: begin a = 10 * px; b = a + 5; end
                    2: begin a = (px == 1 && py == 1) ? 255 : 0; b = 0; end
                    default: begin a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); end
                endcase
                prev_mem[py * w + px] = a;
                curr_mem[py * w + px] = b;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_level(input int w, input int h, input int stall_idx,
                             input int stall_len, input bit rand_ready,
                             input bit poke_start);
        int idx, cyc, rd_cnt, last_xfer, stall_cnt;
        bit got_done, hold, stalled;
        int s_addr, s_ix, s_iy, s_it, s_last;
        idx = 0; cyc = 0; rd_cnt = 0; last_xfer = -1; stall_cnt = 0;
        got_done = 0; hold = 0; stalled = 0;
        s_addr = 0; s_ix = 0; s_iy = 0; s_it = 0; s_last = 0;
        level_width  = 9'(w);
        level_height = 8'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!got_done && cyc < 20000) begin
            if (grad_valid && idx == stall_idx && stall_cnt < stall_len) begin
                grad_ready = 1'b0;
                stall_cnt++;
            end else if (rand_ready) begin
                grad_ready = ($urandom_range(0, 2) != 0);
            end else begin
                grad_ready = 1'b1;
            end
            start = (poke_start && cyc == 12);
            if (start) begin
                level_width  = 9'd2;
                level_height = 8'd2;
            end
            if (hold) begin
                check("hold_valid", int'(grad_valid), 1);
                check("hold_addr", int'(grad_addr), s_addr);
                check("hold_ix", int'(ix), s_ix);
                check("hold_iy", int'(iy), s_iy);
                check("hold_it", int'(it), s_it);
                check("hold_last", int'(grad_last), s_last);
                check("hold_no_rd", int'(rd_en), 0);
            end
            if (grad_valid && grad_ready) begin
                int px, py;
                px = idx % w;
                py = idx / w;
                check("addr", int'(grad_addr), idx);
                check("ix", int'(ix), a_at(w, h, px + 1, py) - a_at(w, h, px - 1, py));
                check("iy", int'(iy), a_at(w, h, px, py + 1) - a_at(w, h, px, py - 1));
                check("it", int'(it), curr_mem[idx] - prev_mem[idx]);
                check("last", int'(grad_last), int'(idx == w * h - 1));
                if (last_xfer >= 0 && !stalled) check("throughput", cyc - last_xfer, 7);
                idx++;
                last_xfer = cyc;
                stalled = 0;
            end
            hold = grad_valid && !grad_ready;
            if (hold) begin
                stalled = 1;
                s_addr = int'(grad_addr); s_ix = int'(ix); s_iy = int'(iy);
                s_it = int'(it); s_last = int'(grad_last);
            end
            if (rd_en) rd_cnt++;
            if (done) begin
                got_done = 1;
                check("done_latency", cyc - last_xfer, 1);
                check("pixel_count", idx, w * h);
                check("read_count", rd_cnt, 5 * w * h);
                check("no_err", int'(err_dims), 0);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        grad_ready = 1'b1;
        if (!got_done) check("level_timeout", 0, 1);
        check("idle_busy", int'(busy), 0);
        check("done_pulse", int'(done), 0);
    endtask

    task automatic bad_start(input int w, input int h);
        level_width  = 9'(w);
        level_height = 8'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", int'(err_dims), 1);
        check("err_done", int'(done), 1);
        check("err_busy", int'(busy), 0);
        check("err_rd", int'(rd_en), 0);
        tick();
        check("err_clear", int'(err_dims), 0);
        check("err_done_clear", int'(done), 0);
        for (int i = 0; i < 4; i++) begin
            check("err_idle_rd", int'(rd_en), 0);
            check("err_idle_busy", int'(busy), 0);
            check("err_idle_valid", int'(grad_valid), 0);
            tick();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_valid"}, int'(grad_valid), 0);
        check({tag, "_last"}, int'(grad_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err_dims), 0);
        check({tag, "_addr"}, int'(grad_addr), 0);
        check({tag, "_ix"}, int'(ix), 0);
        check({tag, "_iy"}, int'(iy), 0);
        check({tag, "_it"}, int'(it), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        grad_ready = 1'b1;
        level_width = '0;
        level_height = '0;
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();

        fill_image(4, 4, 0);
        run_level(4, 4, -1, 0, 1'b0, 1'b0);
        fill_image(4, 4, 1);
        run_level(4, 4, -1, 0, 1'b0, 1'b0);
        fill_image(4, 4, 2);
        run_level(4, 4, -1, 0, 1'b0, 1'b0);

        fill_image(5, 3, 3);
        run_level(5, 3, 3, 10, 1'b0, 1'b0);

        bad_start(1, 4);
        bad_start(321, 4);
        bad_start(4, 1);
        bad_start(4, 241);

        // Abort mid-level, with a start presented during the reset cycle.
        fill_image(4, 4, 3);
        level_width = 9'd4;
        level_height = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_quiet("abort");
        for (int i = 0; i < 5; i++) begin
            check("abort_no_rd", int'(rd_en), 0);
            tick();
        end
        run_level(4, 4, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            int w, h;
            w = int'($urandom_range(2, 8));
            h = int'($urandom_range(2, 6));
            fill_image(w, h, 3);
            run_level(w, h, int'($urandom_range(0, w * h - 1)), 3, t[0], 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
